// File: rtl/gcn_pkg.sv
// Shared types, sizes and the saturation helper for the MAC compute sequencer.
// Contents: bank/operand sizes, the derived accumulator width, the sequencer
// state enum, the per-issue pipeline tag, and sat_to_width().
package gcn_pkg;

  localparam int unsigned BATCH_SIZE   = 128;
  localparam int unsigned DATA_WIDTH   = 32;
  localparam int unsigned WGT_DEPTH    = BATCH_SIZE;
  localparam int unsigned ACT_DEPTH    = BATCH_SIZE;
  localparam int unsigned ACC_WIDTH    = 2 * DATA_WIDTH + $clog2(BATCH_SIZE);

  localparam int unsigned WGT_AW       = $clog2(WGT_DEPTH);
  localparam int unsigned ACT_AW       = $clog2(ACT_DEPTH);
  localparam int unsigned VLEN_W       = WGT_AW + 1;
  localparam int unsigned NOUT_W       = ACT_AW + 1;
  localparam int unsigned PROD_W       = 2 * DATA_WIDTH;
  localparam int unsigned DRAIN_CYCLES = 3;

  // Clamp bounds expressed at accumulator width.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE,
    ERR
  } mac_state_t;

  // Tag carried alongside each issued element through the pipeline.
  typedef struct packed {
    logic              first;
    logic              last;
    logic [ACT_AW-1:0] row;
  } mac_tag_t;

  // Clamp a signed accumulator value into the signed DATA_WIDTH range.
  function automatic logic [DATA_WIDTH-1:0] sat_to_width(
    input logic signed [ACC_WIDTH-1:0] v
  );
    logic [DATA_WIDTH-1:0] r;
    if (v > SAT_MAX) begin
      r = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    end else if (v < SAT_MIN) begin
      r = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
    end else begin
      r = DATA_WIDTH'(v);
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_pipe.sv
// Product / accumulate / write-back pipeline behind the sequencer's read issue.
// Ports:
//   clock, reset         clock and asynchronous active-high reset
//   iss_valid, iss_tag   element issued this cycle (reads in flight) and its tag
//   out_base             first result address for the current pass
//   wgt_rdata, act_rdata operands, valid one cycle after issue
//   act_wen/waddr/wdata  registered result write, three cycles after the
//                        last element of a row was issued
module mac_pipe
  import gcn_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  iss_valid,
  input  mac_tag_t              iss_tag,
  input  logic [ACT_AW-1:0]     out_base,
  input  logic [DATA_WIDTH-1:0] wgt_rdata,
  input  logic [DATA_WIDTH-1:0] act_rdata,
  output logic                  act_wen,
  output logic [ACT_AW-1:0]     act_waddr,
  output logic [DATA_WIDTH-1:0] act_wdata
);

  logic                         s1_valid_q, s1_valid_d;
  mac_tag_t                     s1_tag_q,   s1_tag_d;
  logic                         s2_valid_q, s2_valid_d;
  mac_tag_t                     s2_tag_q,   s2_tag_d;
  logic signed [PROD_W-1:0]     s2_prod_q,  s2_prod_d;
  logic signed [ACC_WIDTH-1:0]  acc_q,      acc_d;
  logic                         wen_q,      wen_d;
  logic [ACT_AW-1:0]            waddr_q,    waddr_d;
  logic [DATA_WIDTH-1:0]        wdata_q,    wdata_d;

  logic signed [PROD_W-1:0]     prod_c;
  logic signed [ACC_WIDTH-1:0]  prod_ext_c;

  // Stage next-state: tag delay, signed multiply, accumulate, saturate on row end.
  always_comb begin
    s1_valid_d = iss_valid;
    s1_tag_d   = iss_tag;
    s2_valid_d = s1_valid_q;
    s2_tag_d   = s1_tag_q;
    s2_prod_d  = s2_prod_q;
    acc_d      = acc_q;
    wen_d      = 1'b0;
    waddr_d    = '0;
    wdata_d    = '0;

    prod_c     = PROD_W'($signed(wgt_rdata)) * PROD_W'($signed(act_rdata));
    prod_ext_c = ACC_WIDTH'(s2_prod_q);

    if (s1_valid_q) begin
      s2_prod_d = prod_c;
    end

    // First element of a row restarts the sum instead of adding to it.
    if (s2_valid_q) begin
      acc_d = s2_tag_q.first ? prod_ext_c : acc_q + prod_ext_c;
    end

    if (s2_valid_q && s2_tag_q.last) begin
      wen_d   = 1'b1;
      waddr_d = out_base + s2_tag_q.row;
      wdata_d = sat_to_width(acc_d);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_tag_q   <= '0;
      s2_prod_q  <= '0;
      acc_q      <= '0;
      wen_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_tag_q   <= s2_tag_d;
      s2_prod_q  <= s2_prod_d;
      acc_q      <= acc_d;
      wen_q      <= wen_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign act_wen   = wen_q;
  assign act_waddr = waddr_q;
  assign act_wdata = wdata_q;

endmodule

// File: rtl/mac_seq.sv
// MAC compute sequencer: streams a weight vector against NUM rows of
// activations from the global buffer and writes saturated dot products back.
// Ports:
//   clock, reset            clock and asynchronous active-high reset
//   start, cfg_*            pass request and its config, sampled only in IDLE
//   busy                    high in every state except IDLE
//   wgt_ren/raddr/rdata     weight bank read (1-cycle read latency)
//   act_ren/raddr/rdata     activation bank read (1-cycle read latency)
//   act_wen/waddr/wdata     result write into the activation write bank
//   mac_done, cfg_err       one-cycle completion pulse; cfg_err marks a rejected config
module mac_seq
  import gcn_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [VLEN_W-1:0]     cfg_vec_len,
  input  logic [NOUT_W-1:0]     cfg_num_out,
  input  logic [ACT_AW-1:0]     cfg_out_base,
  output logic                  busy,
  output logic                  wgt_ren,
  output logic [WGT_AW-1:0]     wgt_raddr,
  input  logic [DATA_WIDTH-1:0] wgt_rdata,
  output logic                  act_ren,
  output logic [ACT_AW-1:0]     act_raddr,
  input  logic [DATA_WIDTH-1:0] act_rdata,
  output logic                  act_wen,
  output logic [ACT_AW-1:0]     act_waddr,
  output logic [DATA_WIDTH-1:0] act_wdata,
  output logic                  mac_done,
  output logic                  cfg_err
);

  localparam int unsigned CFG_PW = VLEN_W + NOUT_W;
  localparam int unsigned SPAN_W = NOUT_W + 1;

  mac_state_t          state_q,    state_d;
  logic [VLEN_W-1:0]   vec_len_q,  vec_len_d;
  logic [NOUT_W-1:0]   num_out_q,  num_out_d;
  logic [ACT_AW-1:0]   out_base_q, out_base_d;
  logic [WGT_AW-1:0]   i_q,        i_d;
  logic [ACT_AW-1:0]   j_q,        j_d;
  logic [ACT_AW-1:0]   act_addr_q, act_addr_d;
  logic [1:0]          drain_q,    drain_d;
  logic                ren_q,      ren_d;
  logic                busy_q,     busy_d;
  logic                done_q,     done_d;
  logic                err_q,      err_d;

  logic [CFG_PW-1:0]   cfg_total_c;
  logic [SPAN_W-1:0]   cfg_span_c;
  logic                cfg_illegal_c;
  logic                last_elem_c;
  logic                last_row_c;
  mac_tag_t            iss_tag_c;

  // Config legality: non-empty, fits the weight bank, and fits the activation bank.
  always_comb begin
    cfg_total_c   = CFG_PW'(cfg_vec_len) * CFG_PW'(cfg_num_out);
    cfg_span_c    = SPAN_W'(cfg_out_base) + SPAN_W'(cfg_num_out);
    cfg_illegal_c = (cfg_vec_len == '0) ||
                    (cfg_num_out == '0) ||
                    (cfg_vec_len > VLEN_W'(WGT_DEPTH)) ||
                    (cfg_total_c > CFG_PW'(ACT_DEPTH)) ||
                    (cfg_span_c  > SPAN_W'(ACT_DEPTH));
  end

  assign last_elem_c = (VLEN_W'(i_q) == (vec_len_q - VLEN_W'(1)));
  assign last_row_c  = (NOUT_W'(j_q) == (num_out_q - NOUT_W'(1)));

  // Next state, counters and the registered state-decoded outputs.
  always_comb begin
    state_d    = state_q;
    vec_len_d  = vec_len_q;
    num_out_d  = num_out_q;
    out_base_d = out_base_q;
    i_d        = i_q;
    j_d        = j_q;
    act_addr_d = act_addr_q;
    drain_d    = drain_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          vec_len_d  = cfg_vec_len;
          num_out_d  = cfg_num_out;
          out_base_d = cfg_out_base;
          i_d        = '0;
          j_d        = '0;
          act_addr_d = '0;
          state_d    = cfg_illegal_c ? ERR : RUN;
        end
      end
      RUN: begin
        // act_addr tracks row_base + i, i.e. the linear issue count.
        act_addr_d = act_addr_q + ACT_AW'(1);
        if (last_elem_c) begin
          i_d = '0;
          if (last_row_c) begin
            j_d        = '0;
            act_addr_d = '0;
            drain_d    = '0;
            state_d    = DRAIN;
          end else begin
            j_d = j_q + ACT_AW'(1);
          end
        end else begin
          i_d = i_q + WGT_AW'(1);
        end
      end
      DRAIN: begin
        if (drain_q == 2'(DRAIN_CYCLES - 1)) begin
          drain_d = '0;
          state_d = DONE;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ren_d  = (state_d == RUN);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE) || (state_d == ERR);
    err_d  = (state_d == ERR);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      vec_len_q  <= '0;
      num_out_q  <= '0;
      out_base_q <= '0;
      i_q        <= '0;
      j_q        <= '0;
      act_addr_q <= '0;
      drain_q    <= '0;
      ren_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_len_q  <= vec_len_d;
      num_out_q  <= num_out_d;
      out_base_q <= out_base_d;
      i_q        <= i_d;
      j_q        <= j_d;
      act_addr_q <= act_addr_d;
      drain_q    <= drain_d;
      ren_q      <= ren_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Tag for the element whose reads are issued this cycle.
  always_comb begin
    iss_tag_c       = '0;
    iss_tag_c.first = (i_q == '0);
    iss_tag_c.last  = last_elem_c;
    iss_tag_c.row   = j_q;
  end

  mac_pipe u_pipe (
    .clock     (clock),
    .reset     (reset),
    .iss_valid (ren_q),
    .iss_tag   (iss_tag_c),
    .out_base  (out_base_q),
    .wgt_rdata (wgt_rdata),
    .act_rdata (act_rdata),
    .act_wen   (act_wen),
    .act_waddr (act_waddr),
    .act_wdata (act_wdata)
  );

  assign busy      = busy_q;
  assign wgt_ren   = ren_q;
  assign act_ren   = ren_q;
  assign wgt_raddr = i_q;
  assign act_raddr = act_addr_q;
  assign mac_done  = done_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_mac_seq.sv
// Self-checking bench for mac_seq: per-cycle compare against a cycle-indexed
// expectation table built from the pass rules, plus literal spot checks.
module tb_mac_seq;
  import gcn_pkg::*;

  localparam int MAXC = 16384;

  logic                  clock, reset, start;
  logic [VLEN_W-1:0]     cfg_vec_len;
  logic [NOUT_W-1:0]     cfg_num_out;
  logic [ACT_AW-1:0]     cfg_out_base;
  logic                  busy, wgt_ren, act_ren, act_wen, mac_done, cfg_err;
  logic [WGT_AW-1:0]     wgt_raddr;
  logic [ACT_AW-1:0]     act_raddr, act_waddr;
  logic [DATA_WIDTH-1:0] wgt_rdata, act_rdata, act_wdata;

  mac_seq dut (
    .clock(clock), .reset(reset), .start(start),
    .cfg_vec_len(cfg_vec_len), .cfg_num_out(cfg_num_out), .cfg_out_base(cfg_out_base),
    .busy(busy),
    .wgt_ren(wgt_ren), .wgt_raddr(wgt_raddr), .wgt_rdata(wgt_rdata),
    .act_ren(act_ren), .act_raddr(act_raddr), .act_rdata(act_rdata),
    .act_wen(act_wen), .act_waddr(act_waddr), .act_wdata(act_wdata),
    .mac_done(mac_done), .cfg_err(cfg_err)
  );

  always #5 clock = ~clock;

  logic [31:0] wgt_mem [0:127];
  logic [31:0] act_mem [0:127];

  // Global-buffer banks with one-cycle read latency.
  always @(posedge clock) begin
    if (wgt_ren) wgt_rdata <= wgt_mem[wgt_raddr];
    if (act_ren) act_rdata <= act_mem[act_raddr];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Expected outputs indexed by cycle number.
  bit          e_busy [MAXC];
  bit          e_ren  [MAXC];
  bit          e_wen  [MAXC];
  bit          e_done [MAXC];
  bit          e_err  [MAXC];
  int          e_wra  [MAXC];
  int          e_ara  [MAXC];
  int          e_wa   [MAXC];
  logic [31:0] e_wd   [MAXC];
  int          model_end = 0;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          wl_addr[$];
  logic [31:0] wl_data[$];
  int          wl_cyc[$];
  int          done_cyc = -1;
  int          err_cyc  = -1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
  endtask

  function automatic logic [31:0] ref_sat(input logic signed [79:0] s);
    if (s > 80'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -80'sd2147483648) return 32'h8000_0000;
    return s[31:0];
  endfunction

  task automatic clear_from(input int c);
    for (int t = c; t < MAXC; t++) begin
      e_busy[t] = 0; e_ren[t] = 0; e_wen[t] = 0; e_done[t] = 0; e_err[t] = 0;
      e_wra[t] = 0; e_ara[t] = 0; e_wa[t] = 0; e_wd[t] = '0;
    end
    model_end = c;
  endtask

  // Start request seen in cycle c: accepted only if the model says idle.
  task automatic model_start(input int c);
    int vl, no, ob, n, t;
    logic signed [79:0] s, a, b;
    if (e_busy[c]) return;
    vl = int'(cfg_vec_len);
    no = int'(cfg_num_out);
    ob = int'(cfg_out_base);
    if (vl == 0 || no == 0 || vl > 128 || vl * no > 128 || ob + no > 128) begin
      e_busy[c+1] = 1; e_done[c+1] = 1; e_err[c+1] = 1;
      model_end = c + 1;
      return;
    end
    n = vl * no;
    for (int k = 0; k < n; k++) begin
      e_ren[c+1+k] = 1;
      e_wra[c+1+k] = k % vl;
      e_ara[c+1+k] = k;
    end
    for (int j = 0; j < no; j++) begin
      s = '0;
      for (int i = 0; i < vl; i++) begin
        a = 80'($signed(wgt_mem[i]));
        b = 80'($signed(act_mem[j*vl+i]));
        s = s + a * b;
      end
      t = c + (j + 1) * vl + 3;
      e_wen[t] = 1;
      e_wa[t]  = (ob + j) % 128;
      e_wd[t]  = ref_sat(s);
    end
    for (int u = c + 1; u <= c + n + 4; u++) e_busy[u] = 1;
    e_done[c+n+4] = 1;
    model_end = c + n + 4;
  endtask

  // Per-cycle compare away from the active edge, then model update.
  always @(negedge clock) begin
    if (cyc >= MAXC - 200) begin
      $display("FAIL cycle_budget cyc=%0d got=%0d exp=%0d", cyc, cyc, MAXC - 200);
      $fatal(1);
    end
    chk("busy",    32'(busy),     32'(e_busy[cyc]));
    chk("wgt_ren", 32'(wgt_ren),  32'(e_ren[cyc]));
    chk("act_ren", 32'(act_ren),  32'(e_ren[cyc]));
    if (e_ren[cyc]) begin
      chk("wgt_raddr", 32'(wgt_raddr), 32'(e_wra[cyc]));
      chk("act_raddr", 32'(act_raddr), 32'(e_ara[cyc]));
    end
    chk("act_wen", 32'(act_wen), 32'(e_wen[cyc]));
    if (e_wen[cyc]) begin
      chk("act_waddr", 32'(act_waddr), 32'(e_wa[cyc]));
      chk("act_wdata", act_wdata, e_wd[cyc]);
    end
    chk("mac_done", 32'(mac_done), 32'(e_done[cyc]));
    chk("cfg_err",  32'(cfg_err),  32'(e_err[cyc]));
    if (act_wen === 1'b1) begin
      wl_addr.push_back(int'(act_waddr));
      wl_data.push_back(act_wdata);
      wl_cyc.push_back(cyc);
    end
    if (mac_done === 1'b1) done_cyc = cyc;
    if (cfg_err === 1'b1) err_cyc = cyc;
    if (start && !reset) model_start(cyc);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_log();
    wl_addr.delete(); wl_data.delete(); wl_cyc.delete();
    done_cyc = -1; err_cyc = -1;
  endtask

  task automatic begin_pass(input int vl, input int no, input int ob, output int s);
    cfg_vec_len  = VLEN_W'(vl);
    cfg_num_out  = NOUT_W'(no);
    cfg_out_base = ACT_AW'(ob);
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (cyc <= model_end && g < 1000) begin
      tick();
      g++;
    end
    if (g >= 1000) chk("wait_idle_timeout", 32'(g), 32'(0));
  endtask

  task automatic run_pass(input int vl, input int no, input int ob, output int s);
    begin_pass(vl, no, ob, s);
    wait_idle();
  endtask

  initial begin
    int s, vl, no, ob;
    bit illegal;
    clock = 1'b0; reset = 1'b1; start = 1'b0;
    cfg_vec_len = '0; cfg_num_out = '0; cfg_out_base = '0;
    wgt_rdata = '0; act_rdata = '0;
    for (int k = 0; k < 128; k++) begin wgt_mem[k] = '0; act_mem[k] = '0; end
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Small integer pass with known results.
    for (int k = 0; k < 4; k++) wgt_mem[k] = 32'(k + 1);
    for (int k = 0; k < 8; k++) act_mem[k] = 32'(k);
    clear_log();
    run_pass(4, 2, 10, s);
    chk("t1_nwrites", 32'(wl_addr.size()), 32'd2);
    if (wl_addr.size() == 2) begin
      chk("t1_addr0", 32'(wl_addr[0]), 32'd10);
      chk("t1_data0", wl_data[0], 32'd20);
      chk("t1_addr1", 32'(wl_addr[1]), 32'd11);
      chk("t1_data1", wl_data[1], 32'd60);
      chk("t1_write_gap", 32'(wl_cyc[1] - wl_cyc[0]), 32'd4);
    end
    chk("t1_done_latency", 32'(done_cyc - s), 32'd12);
    chk("t1_busy_after", 32'(busy), 32'd0);

    // vec_len = 1: a write every cycle.
    wgt_mem[0] = 32'hFFFF_FFFE;
    act_mem[0] = 32'd5; act_mem[1] = 32'hFFFF_FFF9; act_mem[2] = 32'd0;
    clear_log();
    run_pass(1, 3, 20, s);
    chk("t2_nwrites", 32'(wl_addr.size()), 32'd3);
    if (wl_addr.size() == 3) begin
      chk("t2_data0", wl_data[0], 32'hFFFF_FFF6);
      chk("t2_data1", wl_data[1], 32'd14);
      chk("t2_data2", wl_data[2], 32'd0);
      chk("t2_addr2", 32'(wl_addr[2]), 32'd22);
      chk("t2_consecutive", 32'(wl_cyc[2] - wl_cyc[0]), 32'd2);
    end

    // Saturation in both directions.
    wgt_mem[0] = 32'h7FFF_FFFF; wgt_mem[1] = 32'h7FFF_FFFF;
    act_mem[0] = 32'h7FFF_FFFF; act_mem[1] = 32'h7FFF_FFFF;
    clear_log();
    run_pass(2, 1, 0, s);
    chk("t3_pos_clamp", (wl_data.size() > 0) ? wl_data[0] : 32'hDEAD_BEEF, 32'h7FFF_FFFF);
    wgt_mem[0] = 32'h8000_0000; wgt_mem[1] = 32'h8000_0000;
    clear_log();
    run_pass(2, 1, 0, s);
    chk("t3_neg_clamp", (wl_data.size() > 0) ? wl_data[0] : 32'hDEAD_BEEF, 32'h8000_0000);

    // Illegal configs: error pulse one cycle after accept, no traffic.
    clear_log();
    run_pass(0, 1, 0, s);
    chk("t4_err_lat_a", 32'(err_cyc - s), 32'd1);
    chk("t4_done_lat_a", 32'(done_cyc - s), 32'd1);
    clear_log();
    run_pass(128, 2, 0, s);
    chk("t4_err_lat_b", 32'(err_cyc - s), 32'd1);
    chk("t4_nwrites_b", 32'(wl_addr.size()), 32'd0);
    run_pass(2, 8, 121, s);
    run_pass(2, 8, 120, s);
    run_pass(128, 1, 0, s);
    run_pass(1, 128, 0, s);

    // Reset in the middle of a pass, on the cycle of the first write.
    for (int k = 0; k < 128; k++) begin wgt_mem[k] = $urandom; act_mem[k] = $urandom; end
    clear_log();
    begin_pass(8, 4, 0, s);
    repeat (10) tick();
    #2;
    reset = 1'b1;
    clear_from(cyc);
    #1;
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_ren",  32'(wgt_ren | act_ren), 32'd0);
    chk("t5_rst_wen",  32'(act_wen), 32'd0);
    chk("t5_rst_wdata", act_wdata, 32'd0);
    chk("t5_rst_done", 32'(mac_done | cfg_err), 32'd0);
    tick(); tick();
    reset = 1'b0;
    repeat (30) tick();
    chk("t5_no_writes", 32'(wl_addr.size()), 32'd0);
    chk("t5_no_done", 32'(done_cyc), 32'hFFFF_FFFF);
    run_pass(3, 2, 5, s);
    chk("t5_after_writes", 32'(wl_addr.size()), 32'd2);

    // start while busy is ignored.
    clear_log();
    begin_pass(5, 3, 40, s);
    cfg_vec_len = VLEN_W'(2); cfg_num_out = NOUT_W'(2); cfg_out_base = '0;
    start = 1'b1;
    tick(); tick();
    start = 1'b0;
    wait_idle();
    chk("t6_nwrites", 32'(wl_addr.size()), 32'd3);

    // Random passes, some illegal, some with start spam while busy.
    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < 128; k++) begin wgt_mem[k] = $urandom; act_mem[k] = $urandom; end
      if (r % 5 == 4) begin
        for (int k = 0; k < 128; k++) begin
          wgt_mem[k] = 32'($signed($urandom_range(0, 40)) - 20);
          act_mem[k] = 32'($signed($urandom_range(0, 40)) - 20);
        end
      end
      illegal = ($urandom_range(0, 7) == 0);
      if (illegal) begin
        vl = $urandom_range(0, 255); no = $urandom_range(0, 255); ob = $urandom_range(0, 127);
      end else begin
        vl = $urandom_range(1, 16);
        no = $urandom_range(1, (128 / vl < 8) ? 128 / vl : 8);
        ob = $urandom_range(0, 128 - no);
      end
      begin_pass(vl, no, ob, s);
      if (!illegal && vl * no >= 3 && $urandom_range(0, 1) == 1) begin
        cfg_vec_len = VLEN_W'($urandom_range(0, 255));
        cfg_num_out = NOUT_W'($urandom_range(0, 255));
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      wait_idle();
      repeat ($urandom_range(0, 2)) tick();
    end

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
